// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 binary-code-modulation scan engine:
// FSM state encoding, channel positions inside a pixel pair, and clog2.
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    // Channel offsets inside a half-pixel ({R,G,B}, MSB first), in units of BPC bits.
    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    // Half-pixel offsets inside the pixel pair, in units of BPC bits.
    localparam int HALF_TOP_OFS = 3;
    localparam int HALF_BOT_OFS = 0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter that times the DISPLAY window of one bit-plane.
// With HUB75_BRIGHTNESS_EN defined the window is scaled by brightness/256.
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int BPC    = 4,
    parameter int BASE_T = 8,
    parameter int PL_W   = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic [PL_W-1:0] plane,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]      brightness,
`endif
    output logic            done,
    output logic            zero
);

    localparam int T_W = clog2((BASE_T << (BPC - 1)) + 1);

    logic [T_W-1:0] w_base;
    logic [T_W-1:0] w_dur;
    logic [T_W-1:0] r_count;
    logic           r_run;

    assign w_base = T_W'(BASE_T) << plane;

`ifdef HUB75_BRIGHTNESS_EN
    logic [T_W+7:0] w_prod;
    assign w_prod = (T_W+8)'(w_base) * (T_W+8)'(brightness);
    assign w_dur  = w_prod[T_W+7:8];
`else
    assign w_dur  = w_base;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
            r_run   <= 1'b0;
        end else if (load) begin
            r_count <= w_dur - T_W'(1);
            r_run   <= (w_dur != '0);
        end else if (r_run) begin
            if (r_count == '0) begin
                r_run <= 1'b0;
            end else begin
                r_count <= r_count - T_W'(1);
            end
        end
    end

    // done marks the final cycle of the window, so the FSM can leave on that edge.
    assign done = r_run && (r_count == '0);
    assign zero = (w_dur == '0);

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 LED-matrix scan engine: fetches pixel pairs, shifts one bit-plane per
// pass and shows it for a binary-weighted time. Option macro: HUB75_BRIGHTNESS_EN.
module hub75_bcm_scan
    import hub75_pkg::*;
#(
    parameter int COLS   = 64,
    parameter int ADDR_W = 5,
    parameter int BPC    = 4,
    parameter int BASE_T = 8
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]                        brightness,
`endif
    output logic [ADDR_W+clog2(COLS)-1:0]     rd_addr,
    input  logic [6*BPC-1:0]                  rd_data,
    output logic [ADDR_W-1:0]                 A,
    output logic [2:0]                        RGB0,
    output logic [2:0]                        RGB1,
    output logic                              LATCH,
    output logic                              BLANK,
    output logic                              CLK_SCREEN,
    output logic                              frame_start
);

    localparam int COL_W = clog2(COLS);
    localparam int PL_W  = (BPC > 1) ? clog2(BPC) : 1;
    localparam int RA_W  = ADDR_W + COL_W;

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_row, w_row_next;
    logic [PL_W-1:0]     r_plane, w_plane_next;
    logic [COL_W-1:0]    r_col, w_col_next;
    logic                r_half, w_half_next;

    logic [RA_W-1:0]     r_rd_addr, w_rd_addr_next;
    logic [ADDR_W-1:0]   r_a, w_a_next;
    logic [2:0]          r_rgb0, w_rgb0_next;
    logic [2:0]          r_rgb1, w_rgb1_next;
    logic                r_latch, w_latch_next;
    logic                r_blank, w_blank_next;
    logic                r_clk_screen, w_clk_screen_next;
    logic                r_frame_start, w_frame_start_next;

    logic                w_last_plane;
    logic [ADDR_W-1:0]   w_row_adv;
    logic [PL_W-1:0]     w_plane_adv;
    logic [2:0]          w_top_bits;
    logic [2:0]          w_bot_bits;
    logic                w_exit;
    logic                w_timer_load;
    logic                w_timer_done;
    logic                w_timer_zero;

    assign w_last_plane = (r_plane == PL_W'(BPC - 1));
    assign w_row_adv    = w_last_plane ? r_row + ADDR_W'(1) : r_row;
    assign w_plane_adv  = w_last_plane ? '0 : r_plane + PL_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi = gi + 1) begin : g_chan
            logic [BPC-1:0] w_top_ch;
            logic [BPC-1:0] w_bot_ch;
            assign w_top_ch       = rd_data[(HALF_TOP_OFS + gi)*BPC +: BPC];
            assign w_bot_ch       = rd_data[(HALF_BOT_OFS + gi)*BPC +: BPC];
            assign w_top_bits[gi] = w_top_ch[r_plane];
            assign w_bot_bits[gi] = w_bot_ch[r_plane];
        end
    endgenerate

    hub75_bcm_timer #(
        .BPC    (BPC),
        .BASE_T (BASE_T),
        .PL_W   (PL_W)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .load       (w_timer_load),
        .plane      (r_plane),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .done       (w_timer_done),
        .zero       (w_timer_zero)
    );

    // Outputs are computed for the state being entered, then registered.
    // rd_addr leads the shifted column by one so that each column's data is
    // already sitting on rd_data when its RGB register loads; outside SHIFT it
    // points at column 0 of the row the next FETCH will use.
    always_comb begin
        w_state_next       = r_state;
        w_row_next         = r_row;
        w_plane_next       = r_plane;
        w_col_next         = r_col;
        w_half_next        = r_half;
        w_rd_addr_next     = r_rd_addr;
        w_a_next           = r_a;
        w_rgb0_next        = 3'b000;
        w_rgb1_next        = 3'b000;
        w_latch_next       = 1'b0;
        w_blank_next       = 1'b1;
        w_clk_screen_next  = 1'b0;
        w_frame_start_next = 1'b0;
        w_timer_load       = 1'b0;
        w_exit             = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next       = ST_FETCH;
                    w_row_next         = '0;
                    w_plane_next       = '0;
                    w_rd_addr_next     = '0;
                    w_frame_start_next = 1'b1;
                end
            end
            ST_FETCH: begin
                w_state_next   = ST_SHIFT;
                w_col_next     = '0;
                w_half_next    = 1'b0;
                w_rgb0_next    = w_top_bits;
                w_rgb1_next    = w_bot_bits;
                w_rd_addr_next = {r_row, COL_W'(1)};
            end
            ST_SHIFT: begin
                if (!r_half) begin
                    w_half_next       = 1'b1;
                    w_clk_screen_next = 1'b1;
                    w_rgb0_next       = r_rgb0;
                    w_rgb1_next       = r_rgb1;
                end else if (r_col == COL_W'(COLS - 1)) begin
                    w_state_next   = ST_LATCH;
                    w_latch_next   = 1'b1;
                    w_a_next       = r_row;
                    w_rd_addr_next = {w_row_adv, {COL_W{1'b0}}};
                end else begin
                    w_half_next    = 1'b0;
                    w_col_next     = r_col + COL_W'(1);
                    w_rgb0_next    = w_top_bits;
                    w_rgb1_next    = w_bot_bits;
                    w_rd_addr_next = {r_row, r_col + COL_W'(2)};
                end
            end
            ST_LATCH: begin
                w_timer_load = 1'b1;
                if (w_timer_zero) begin
                    w_exit = 1'b1;
                end else begin
                    w_state_next = ST_DISPLAY;
                    w_blank_next = 1'b0;
                end
            end
            ST_DISPLAY: begin
                if (w_timer_done) begin
                    w_exit = 1'b1;
                end else begin
                    w_blank_next = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_exit) begin
            w_row_next   = w_row_adv;
            w_plane_next = w_plane_adv;
            if (enable) begin
                w_state_next       = ST_FETCH;
                w_rd_addr_next     = {w_row_adv, {COL_W{1'b0}}};
                w_frame_start_next = (w_row_adv == '0) && (w_plane_adv == '0);
            end else begin
                w_state_next   = ST_IDLE;
                w_rd_addr_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_row         <= '0;
            r_plane       <= '0;
            r_col         <= '0;
            r_half        <= 1'b0;
            r_rd_addr     <= '0;
            r_a           <= '0;
            r_rgb0        <= 3'b000;
            r_rgb1        <= 3'b000;
            r_latch       <= 1'b0;
            r_blank       <= 1'b1;
            r_clk_screen  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_row         <= w_row_next;
            r_plane       <= w_plane_next;
            r_col         <= w_col_next;
            r_half        <= w_half_next;
            r_rd_addr     <= w_rd_addr_next;
            r_a           <= w_a_next;
            r_rgb0        <= w_rgb0_next;
            r_rgb1        <= w_rgb1_next;
            r_latch       <= w_latch_next;
            r_blank       <= w_blank_next;
            r_clk_screen  <= w_clk_screen_next;
            r_frame_start <= w_frame_start_next;
        end
    end

    // The panel goes dark the moment reset asserts, without waiting for a clock.
    assign BLANK       = r_blank | ~resetn;
    assign rd_addr     = r_rd_addr;
    assign A           = r_a;
    assign RGB0        = r_rgb0;
    assign RGB1        = r_rgb1;
    assign LATCH       = r_latch;
    assign CLK_SCREEN  = r_clk_screen;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Directed bench for hub75_bcm_scan (COLS=4, ADDR_W=1, BPC=2, BASE_T=4).
// Set HUB75_BRIGHTNESS_EN to also exercise the brightness scaling.
module tb_hub75_bcm_scan;

    localparam int COLS   = 4;
    localparam int ADDR_W = 1;
    localparam int BPC    = 2;
    localparam int BASE_T = 4;
    localparam int AW     = 3;
    localparam int DW     = 6 * BPC;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [ADDR_W-1:0] A;
    logic [2:0]    RGB0;
    logic [2:0]    RGB1;
    logic          LATCH;
    logic          BLANK;
    logic          CLK_SCREEN;
    logic          frame_start;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0]    brightness = 8'd128;
`endif

    logic [DW-1:0] fb [0:7];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int frame_t0 = 0;

    hub75_bcm_scan #(
        .COLS   (COLS),
        .ADDR_W (ADDR_W),
        .BPC    (BPC),
        .BASE_T (BASE_T)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .A           (A),
        .RGB0        (RGB0),
        .RGB1        (RGB1),
        .LATCH       (LATCH),
        .BLANK       (BLANK),
        .CLK_SCREEN  (CLK_SCREEN),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= fb[rd_addr];
        cyc     <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_d(input int plane);
`ifdef HUB75_BRIGHTNESS_EN
        return ((BASE_T << plane) * int'(brightness)) >> 8;
`else
        return BASE_T << plane;
`endif
    endfunction

    // Only row 0 col 2 top R (2'b10) and row 1 col 0 bottom B (2'b01) are lit.
    function automatic logic [2:0] exp_rgb0(input int row, input int plane, input int c);
        return (row == 0 && c == 2 && plane == 1) ? 3'b100 : 3'b000;
    endfunction

    function automatic logic [2:0] exp_rgb1(input int row, input int plane, input int c);
        return (row == 1 && c == 0 && plane == 0) ? 3'b001 : 3'b000;
    endfunction

    // Entered on the FETCH cycle; leaves on the cycle after DISPLAY ends.
    task automatic do_plane(input int row, input int plane, input int drop_col);
        int d;
        d = exp_d(plane);
        $display("plane row=%0d plane=%0d display=%0d t=%0d", row, plane, d, cyc);
        chk("fetch_frame_start", 32'(frame_start), 32'(row == 0 && plane == 0));
        chk("fetch_rd_addr", 32'(rd_addr), row * COLS);
        chk("fetch_blank", 32'(BLANK), 1);
        for (int c = 0; c < COLS; c++) begin
            step();
            if (c == drop_col) enable = 1'b0;
            chk("shift_lo_clk", 32'(CLK_SCREEN), 0);
            chk("shift_lo_rgb0", 32'(RGB0), 32'(exp_rgb0(row, plane, c)));
            chk("shift_lo_rgb1", 32'(RGB1), 32'(exp_rgb1(row, plane, c)));
            chk("shift_rd_addr", 32'(rd_addr), row * COLS + (c + 1) % COLS);
            chk("shift_blank", 32'(BLANK), 1);
            step();
            chk("shift_hi_clk", 32'(CLK_SCREEN), 1);
            chk("shift_hi_rgb0", 32'(RGB0), 32'(exp_rgb0(row, plane, c)));
            chk("shift_hi_rgb1", 32'(RGB1), 32'(exp_rgb1(row, plane, c)));
            chk("shift_hi_latch", 32'(LATCH), 0);
        end
        step();
        chk("latch_pulse", 32'(LATCH), 1);
        chk("latch_clk", 32'(CLK_SCREEN), 0);
        chk("latch_blank", 32'(BLANK), 1);
        chk("latch_row_a", 32'(A), row);
        for (int k = 0; k < d; k++) begin
            step();
            chk("disp_blank", 32'(BLANK), 0);
            chk("disp_latch", 32'(LATCH), 0);
            chk("disp_row_a", 32'(A), row);
        end
        step();
        chk("disp_end_blank", 32'(BLANK), 1);
    endtask

    initial begin
        int frame_len;
        int lows;
        for (int i = 0; i < 8; i++) fb[i] = '0;
        fb[2] = 12'h800;
        fb[4] = 12'h001;
        frame_len = 0;
        for (int b = 0; b < BPC; b++) frame_len += 2 * COLS + 2 + exp_d(b);
        frame_len = frame_len * (1 << ADDR_W);

        // reset held, then released with enable low
        repeat (3) step();
        $display("reset held t=%0d", cyc);
        chk("rst_blank", 32'(BLANK), 1);
        chk("rst_latch", 32'(LATCH), 0);
        chk("rst_clk_screen", 32'(CLK_SCREEN), 0);
        chk("rst_rgb0", 32'(RGB0), 0);
        chk("rst_rgb1", 32'(RGB1), 0);
        chk("rst_a", 32'(A), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        resetn = 1'b1;
        repeat (4) step();
        $display("reset released, enable low t=%0d", cyc);
        chk("idle_blank", 32'(BLANK), 1);
        chk("idle_clk_screen", 32'(CLK_SCREEN), 0);
        chk("idle_latch", 32'(LATCH), 0);
        chk("idle_frame_start", 32'(frame_start), 0);
        chk("idle_rd_addr", 32'(rd_addr), 0);

        // one full frame
        enable = 1'b1;
        step();
        frame_t0 = cyc;
        do_plane(0, 0, -1);
        do_plane(0, 1, -1);
        do_plane(1, 0, -1);
        do_plane(1, 1, -1);
        chk("frame_length", cyc - frame_t0, frame_len);

        // next frame: A back to 0, then enable dropped mid-SHIFT of row 0 plane 1
        do_plane(0, 0, -1);
        do_plane(0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            $display("idle after drop t=%0d", cyc);
            chk("drop_idle_blank", 32'(BLANK), 1);
            chk("drop_idle_frame_start", 32'(frame_start), 0);
            chk("drop_idle_clk", 32'(CLK_SCREEN), 0);
            chk("drop_idle_latch", 32'(LATCH), 0);
            step();
        end
        enable = 1'b1;
        step();
        do_plane(0, 0, -1);

        // reset in the middle of DISPLAY of row 0 plane 1
        repeat (1 + 2 * COLS + 1 + 1) step();
        $display("reset mid-display t=%0d", cyc);
        chk("pre_rst_blank", 32'(BLANK), 0);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_blank", 32'(BLANK), 1);
        chk("async_rst_latch", 32'(LATCH), 0);
        chk("async_rst_a", 32'(A), 0);
        chk("async_rst_rd_addr", 32'(rd_addr), 0);
        step();
        resetn = 1'b1;
        enable = 1'b0;
        step();
        chk("post_rst_blank", 32'(BLANK), 1);

`ifdef HUB75_BRIGHTNESS_EN
        // brightness 0: every DISPLAY is skipped, panel never lit
        brightness = 8'd0;
        enable = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (BLANK == 1'b0) lows++;
        end
        $display("brightness zero run t=%0d", cyc);
        chk("bright0_blank_low_cycles", lows, 0);
        enable = 1'b0;
`else
        lows = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hub75_bcm_scan.md
# hub75_bcm_scan

Parametrised HUB75 LED-matrix scan engine. It is the successor to the fixed single-bit panel output on the SOC's A/RGB0/RGB1/LATCH/BLANK/CLK_SCREEN pins. It reads pixel pairs (top and bottom half) from a synchronous framebuffer and shifts them out one bit-plane at a time. Each plane is shown for a binary-weighted time (binary code modulation), which gives 2^BPC levels per colour. It sits between the SOC framebuffer RAM and the panel pins.

## Interface
- COLS, 64, panel columns per row; power of two, at least 2.
- ADDR_W, 5, row-address width; the panel has 2^ADDR_W row pairs.
- BPC, 4, bits per colour channel; 1 to 8.
- BASE_T, 8, display cycles for plane 0; plane b is displayed for BASE_T<<b cycles.
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  run scanning while high
- rd_addr  out  ADDR_W+log2(COLS)  framebuffer address {row, col}
- rd_data  in  6*BPC  pixel pair; 1-cycle read latency. Layout is {top R,G,B, bottom R,G,B}, MSB first, each channel BPC bits.
- A  out  ADDR_W  panel row address
- RGB0, RGB1  out  3 each  {R,G,B} bit of the current plane, top and bottom half
- LATCH  out  1  panel latch strobe
- BLANK  out  1  panel output-disable (high = dark)
- CLK_SCREEN  out  1  panel shift clock
- frame_start  out  1  one-cycle pulse at the start of each frame

## Operation
- States: IDLE, FETCH, SHIFT, LATCH, DISPLAY. Scan order is row 0 to 2^ADDR_W−1; inside each row, plane 0 to BPC−1.
- IDLE: BLANK=1. LATCH, CLK_SCREEN, RGB0 and RGB1 are 0. A holds its value.
  - Leaves IDLE when enable=1; goes to FETCH at row 0, plane 0.
- FETCH: 1 cycle. Presents rd_addr={row,0}. BLANK=1.
  - frame_start=1 in this cycle when row=0 and plane=0.
- SHIFT: 2*COLS cycles.
  - Column c owns cycles 2c and 2c+1.
  - Cycle 2c: CLK_SCREEN=0, and RGB0/RGB1 carry bit `plane` of column c's channels.
  - Cycle 2c+1: CLK_SCREEN=1, RGB unchanged.
  - rd_addr={row,c+1} is presented early enough to meet the 1-cycle read latency.
  - BLANK=1 throughout.
- LATCH: 1 cycle. LATCH=1, BLANK=1, CLK_SCREEN=0. A is updated to `row` in this cycle.
- DISPLAY: BLANK=0 for D cycles, D = BASE_T<<plane.
  - On exit, BLANK=1 and the plane/row counters advance.
  - After the last plane of the last row, row wraps to 0.
- After DISPLAY: if enable=1, go to FETCH; otherwise go to IDLE.
  - enable falling mid-plane never truncates SHIFT, LATCH or DISPLAY.
- Counter wrap: plane wraps at BPC−1 and row advances; row wraps at 2^ADDR_W−1.
- Asynchronous reset (any state): state goes to IDLE and row, plane and col go to 0.
  - Output values: A=0, RGB0=RGB1=0, LATCH=0, BLANK=1, CLK_SCREEN=0, rd_addr=0, frame_start=0.
  - BLANK must go high combinationally with reset assertion, not on the next edge.

## Timing
- All outputs are registered, except that BLANK is also forced by reset.
- Cycles per plane: 1 + 2*COLS + 1 + D.
- Cycles per frame: 2^ADDR_W × sum over b of (2*COLS + 2 + BASE_T<<b).
- The panel samples RGB on the rising edge of CLK_SCREEN. Data is stable for 1 cycle before that edge and 1 cycle after it.
- LATCH is never high while CLK_SCREEN=1 or BLANK=0.

## Configuration
- HUB75_BRIGHTNESS_EN defined:
  - Adds input `brightness` [7:0].
  - D = ((BASE_T<<plane) × brightness) >> 8. If D=0, DISPLAY is skipped: BLANK stays 1 and the next state is taken directly.
  - brightness is sampled on entry to DISPLAY.
- HUB75_BRIGHTNESS_EN undefined: the port is absent and D = BASE_T<<plane.

## Structure
- Shared package hub75_pkg:
  - state enum;
  - channel offset constants (R/G/B position within a half-pixel);
  - function clog2.
- One sub-module, hub75_bcm_timer: loadable down-counter for DISPLAY with a done pulse. It also contains the brightness multiply when the macro is defined.

## Test plan
All scenarios use COLS=4, ADDR_W=1, BPC=2, BASE_T=4.
- Reset held, then released with enable=0 → outputs stay at reset values: BLANK=1, all others 0.
- enable=1 →
  - frame_start pulses once;
  - 4 CLK_SCREEN rises, then LATCH=1 for 1 cycle;
  - BLANK=0 for 4 cycles (plane 0), then 8 cycles (plane 1);
  - frame length is 2×(10+4 + 10+8) = 64 cycles.
- Framebuffer row 0, col 2 top R=2'b10, all else 0 → RGB0[2]=0 at the 3rd rise in plane 0 and 1 at the 3rd rise in plane 1; all other sampled bits are 0.
- Row-1 planes → rd_addr MSB=1 during SHIFT; A=1 from LATCH through DISPLAY; A=0 again at the start of the next frame.
- Scenario 5: enable dropped mid-SHIFT of row 0 plane 1.
  - Required: the plane completes (8-cycle DISPLAY), then IDLE with BLANK=1.
  - Re-enable: frame_start pulses and scanning restarts at row 0, plane 0.
- HUB75_BRIGHTNESS_EN defined:
  - brightness=128 → plane 0 displays 2 cycles, plane 1 displays 4;
  - brightness=0 → BLANK never goes low;
  - reset asserted mid-DISPLAY → BLANK=1 immediately.
